uart_rx: RTL

//  - Asynchronous serial receiver, 8N1 (8E1 with parity option), LSB first, line idle high.
//  - Pairs with the TRAX UART transmitter at the same CLKS_PER_BIT.
//  - Synchronises the rx line, finds the start bit and samples every bit at mid-bit.
//  - Presents each received byte on a parallel bus with a one-cycle valid strobe.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_sync.sv | 41 ++++
 rtl/uart_rx.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
// FSM state encoding, frame geometry and the bit-counter width live here.
`timescale 1ns/1ps

package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int CNT_W     = 12;

    localparam logic [2:0] ST_IDLE   = 3'b000;
    localparam logic [2:0] ST_START  = 3'b001;
    localparam logic [2:0] ST_DATA   = 3'b010;
    localparam logic [2:0] ST_STOP   = 3'b011;
    localparam logic [2:0] ST_PARITY = 3'b100;

    // High when data plus its parity bit do not have even parity.
    function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] data,
                                             input logic                 par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: SYNC_STAGES-deep synchroniser for the asynchronous rx line.
// Every flop resets to 1 so the receiver sees an idle line straight out of reset.
`timescale 1ns/1ps

module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_reg;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                // First stage captures the raw asynchronous input.
                always_ff @(posedge clock or negedge reset_n) begin
                    if (!reset_n)
                        sync_reg[gi] <= 1'b1;
                    else
                        sync_reg[gi] <= d;
                end
            end else begin : g_next
                // Later stages give the first flop time to resolve metastability.
                always_ff @(posedge clock or negedge reset_n) begin
                    if (!reset_n)
                        sync_reg[gi] <= 1'b1;
                    else
                        sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign q = sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, LSB first, line idle high, mid-bit sampling.
// Define UART_RX_PARITY_EN to add an even-parity bit (8E1) and the parity_err pulse.
`timescale 1ns/1ps

module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 rx_busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    // START stops at the middle of the start bit; every later state waits a full bit.
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic                 rx_s;

    logic [2:0]           state_reg,     state_next;
    logic [CNT_W-1:0]     clk_cnt_reg,   clk_cnt_next;
    logic [2:0]           bit_idx_reg,   bit_idx_next;
    logic [DATA_BITS-1:0] shift_reg,     shift_next;
    logic [DATA_BITS-1:0] rx_data_reg,   rx_data_next;
    logic                 rx_valid_reg,  rx_valid_next;
    logic                 frame_err_reg, frame_err_next;
    // Set by a bad stop bit: a held-low line must go high before a new start is accepted.
    logic                 wait_high_reg, wait_high_next;
`ifdef UART_RX_PARITY_EN
    logic                 parity_bit_reg, parity_bit_next;
    logic                 parity_err_reg, parity_err_next;
`endif

    uart_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (rx),
        .q       (rx_s)
    );

    // Next-state logic: frame FSM, bit timing, shift register and output strobes.
    always_comb begin
        state_next     = state_reg;
        clk_cnt_next   = clk_cnt_reg;
        bit_idx_next   = bit_idx_reg;
        shift_next     = shift_reg;
        rx_data_next   = rx_data_reg;
        rx_valid_next  = 1'b0;
        frame_err_next = 1'b0;
        wait_high_next = wait_high_reg;
`ifdef UART_RX_PARITY_EN
        parity_bit_next = parity_bit_reg;
        parity_err_next = 1'b0;
`endif
        case (state_reg)
            ST_IDLE: begin
                clk_cnt_next = '0;
                bit_idx_next = '0;
                if (wait_high_reg) begin
                    if (rx_s)
                        wait_high_next = 1'b0;
                end else if (!rx_s) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (clk_cnt_reg == HALF_CNT) begin
                    clk_cnt_next = '0;
                    // A start bit that is gone by its midpoint was noise.
                    state_next   = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    clk_cnt_next = clk_cnt_reg + 1'b1;
                end
            end
            ST_DATA: begin
                if (clk_cnt_reg == TERM_CNT) begin
                    clk_cnt_next            = '0;
                    shift_next[bit_idx_reg] = rx_s;
                    if (bit_idx_reg == 3'(DATA_BITS - 1)) begin
                        bit_idx_next = '0;
`ifdef UART_RX_PARITY_EN
                        state_next   = ST_PARITY;
`else
                        state_next   = ST_STOP;
`endif
                    end else begin
                        bit_idx_next = bit_idx_reg + 1'b1;
                    end
                end else begin
                    clk_cnt_next = clk_cnt_reg + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (clk_cnt_reg == TERM_CNT) begin
                    clk_cnt_next    = '0;
                    parity_bit_next = rx_s;
                    state_next      = ST_STOP;
                end else begin
                    clk_cnt_next = clk_cnt_reg + 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (clk_cnt_reg == TERM_CNT) begin
                    // Returning to IDLE at mid-stop leaves half a bit to catch the next start.
                    clk_cnt_next = '0;
                    state_next   = ST_IDLE;
                    if (rx_s) begin
                        rx_valid_next = 1'b1;
                        rx_data_next  = shift_reg;
                    end else begin
                        frame_err_next = 1'b1;
                        wait_high_next = 1'b1;
                    end
`ifdef UART_RX_PARITY_EN
                    parity_err_next = parity_mismatch(shift_reg, parity_bit_reg);
`endif
                end else begin
                    clk_cnt_next = clk_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next   = ST_IDLE;
                clk_cnt_next = '0;
                bit_idx_next = '0;
            end
        endcase
    end

    // State registers; reset aborts any frame in progress without pulses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            clk_cnt_reg   <= '0;
            bit_idx_reg   <= '0;
            shift_reg     <= '0;
            rx_data_reg   <= '0;
            rx_valid_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            wait_high_reg <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit_reg <= 1'b0;
            parity_err_reg <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            clk_cnt_reg   <= clk_cnt_next;
            bit_idx_reg   <= bit_idx_next;
            shift_reg     <= shift_next;
            rx_data_reg   <= rx_data_next;
            rx_valid_reg  <= rx_valid_next;
            frame_err_reg <= frame_err_next;
            wait_high_reg <= wait_high_next;
`ifdef UART_RX_PARITY_EN
            parity_bit_reg <= parity_bit_next;
            parity_err_reg <= parity_err_next;
`endif
        end
    end

    assign rx_data   = rx_data_reg;
    assign rx_valid  = rx_valid_reg;
    assign frame_err = frame_err_reg;
    assign rx_busy   = (state_reg != ST_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_reg;
`endif

endmodule
